// File: rtl/def.sv
// Image RAM address sequencer: after a host kick and a K-cycle delay, walks each
// strip of P rows row-major, then the matching strip of P columns column-major.
module def #(
    parameter int IMAGE_SIZE       = 8,
    parameter int PARTITION_SIZE   = 2,
    parameter int NO_OF_PARTITIONS = 4,
    localparam int AW = (IMAGE_SIZE * IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE * IMAGE_SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hs_kick,
    input  logic          ir_enable,
    output logic          ir_kick,
    output logic          ir_done,
    output logic [AW-1:0] ir_addr
);

    localparam int N    = IMAGE_SIZE;
    localparam int P    = PARTITION_SIZE;
    localparam int K    = NO_OF_PARTITIONS;
    localparam int PN   = P * N;
    localparam int MAXV = (N > P) ? ((N > K) ? N : K) : ((P > K) ? P : K);
    localparam int CW   = $clog2(MAXV + 1);
    localparam int XW   = $clog2(PN + 1);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        DELAY  = 2'd1,
        ADDR_X = 2'd2,
        ADDR_Y = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] dly_cnt;
    logic [CW-1:0] p_cnt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] c_cnt;
    logic [XW-1:0] x_cnt;

    logic dly_last, last_x, last_r, last_c, last_p;
    logic [AW-1:0] x_addr, y_addr;

    assign dly_last = (dly_cnt == CW'(K - 1));
    assign last_x   = (x_cnt == XW'(PN - 1));
    assign last_r   = (r_cnt == CW'(N - 1));
    assign last_c   = (c_cnt == CW'(P - 1));
    assign last_p   = (p_cnt == CW'(K - 1));

    // Everything is evaluated in AW bits so addresses wrap modulo the RAM size.
    assign x_addr = AW'(p_cnt) * AW'(PN) + AW'(x_cnt);
    assign y_addr = AW'(r_cnt) * AW'(N) + AW'(p_cnt) * AW'(P) + AW'(c_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= READY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ir_kick   = 1'b0;
        ir_done   = 1'b0;
        ir_addr   = '0;
        case (state)
            READY: begin
                if (hs_kick) state_nxt = DELAY;
            end
            DELAY: begin
                ir_kick = dly_last;
                if (dly_last) state_nxt = ADDR_X;
            end
            ADDR_X: begin
                ir_addr = x_addr;
                if (ir_enable && last_x) state_nxt = ADDR_Y;
            end
            ADDR_Y: begin
                ir_addr = y_addr;
                if (ir_enable && last_r && last_c) begin
                    ir_done   = last_p;
                    state_nxt = last_p ? READY : ADDR_X;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    // Counters advance only on accepted addresses; ir_enable=0 freezes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_cnt <= '0;
            p_cnt   <= '0;
            r_cnt   <= '0;
            c_cnt   <= '0;
            x_cnt   <= '0;
        end else begin
            case (state)
                READY: begin
                    dly_cnt <= '0;
                    p_cnt   <= '0;
                    r_cnt   <= '0;
                    c_cnt   <= '0;
                    x_cnt   <= '0;
                end
                DELAY: begin
                    dly_cnt <= dly_last ? '0 : dly_cnt + CW'(1);
                end
                ADDR_X: begin
                    if (ir_enable) x_cnt <= last_x ? '0 : x_cnt + XW'(1);
                end
                ADDR_Y: begin
                    if (ir_enable) begin
                        if (last_r) begin
                            r_cnt <= '0;
                            if (last_c) begin
                                c_cnt <= '0;
                                p_cnt <= last_p ? '0 : p_cnt + CW'(1);
                            end else begin
                                c_cnt <= c_cnt + CW'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_def.sv
// Directed bench for def at N=8, P=2, K=4: kick/delay timing, full address
// order with steady and random ir_enable, back-to-back runs, mid-run reset.
module tb_def;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int K  = 4;
    localparam int AW = 6;
    localparam int TOTAL = 2 * N * N;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hs_kick;
    logic          ir_enable;
    logic          ir_kick;
    logic          ir_done;
    logic [AW-1:0] ir_addr;

    int checks   = 0;
    int failures = 0;
    int exp_addr [TOTAL];

    def #(.IMAGE_SIZE(N), .PARTITION_SIZE(P), .NO_OF_PARTITIONS(K)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hs_kick   (hs_kick),
        .ir_enable (ir_enable),
        .ir_kick   (ir_kick),
        .ir_done   (ir_done),
        .ir_addr   (ir_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_addr"}, 32'(ir_addr), 0);
        chk({tag, "_kick"}, 32'(ir_kick), 0);
        chk({tag, "_done"}, 32'(ir_done), 0);
    endtask

    // hs_kick for one edge, then K delay cycles with ir_kick only in the last.
    task automatic do_kick;
        hs_kick = 1'b1;
        tick();
        hs_kick = 1'b0;
        for (int d = 0; d < K; d++) begin
            chk("dly_kick", 32'(ir_kick), (d == K - 1) ? 1 : 0);
            chk("dly_addr", 32'(ir_addr), 0);
            chk("dly_done", 32'(ir_done), 0);
            tick();
        end
    endtask

    task automatic run_addr(input bit rnd, input int stop);
        int i   = 0;
        int cyc = 0;
        bit en;
        while (i < stop && cyc < 4000) begin
            en        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ir_enable = en;
            hs_kick   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("addr", 32'(ir_addr), 32'(exp_addr[i]));
            chk("done", 32'(ir_done), (en && i == TOTAL - 1) ? 1 : 0);
            chk("kick_run", 32'(ir_kick), 0);
            @(posedge clk);
            #1;
            if (en) i++;
            cyc++;
        end
        hs_kick = 1'b0;
        chk("accept_count", 32'(i), 32'(stop));
    endtask

    initial begin
        int idx = 0;
        for (int p = 0; p < K; p++) begin
            for (int k = 0; k < P * N; k++) exp_addr[idx++] = p * P * N + k;
            for (int c = 0; c < P; c++)
                for (int r = 0; r < N; r++) exp_addr[idx++] = r * N + p * P + c;
        end

        reset_n   = 1'b0;
        hs_kick   = 1'b0;
        ir_enable = 1'b0;
        #3;
        chk_idle("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // Run 1: ir_enable held high.
        ir_enable = 1'b1;
        do_kick();
        run_addr(1'b0, TOTAL);
        chk_idle("after_run1");

        // Run 2 kicked in the cycle after ir_done, random ir_enable.
        do_kick();
        run_addr(1'b1, TOTAL);
        chk_idle("after_run2");
        ir_enable = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_idle("ready_hold");
        end

        // Run 3: abandoned partway through partition 2's column pass.
        do_kick();
        run_addr(1'b0, 90);
        chk("pre_reset_addr", 32'(ir_addr), 32'(exp_addr[90]));
        reset_n = 1'b0;
        #1;
        chk_idle("async_reset");
        tick();
        chk_idle("in_reset");
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_idle("idle_after_reset");
        end

        // Run 4: full replay from the start.
        do_kick();
        run_addr(1'b0, TOTAL);
        chk_idle("after_run4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
